// File: rtl/bus_pkg.sv
// Shared types and defaults for the serial system bus arbiter.
package bus_pkg;

  localparam int MASTER_NO_DEF = 2;
  localparam int SLAVE_NO_DEF  = 3;
  // Fixed-width slave index so the split entry can live in the package.
  // This width allows up to 256 slaves.
  localparam int SLAVE_IDX_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                   valid;
    logic [SLAVE_IDX_W-1:0] slave_idx;
  } split_entry_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// Master-port handshake and slave split/resume signals around the arbiter.
// The master modport is the arbiter's side. The slave modport is the side
// that drives requests and split/resume pulses.
interface bus_arbiter_if
  import bus_pkg::*;
#(
  parameter int MASTER_NO = MASTER_NO_DEF,
  parameter int SLAVE_NO  = SLAVE_NO_DEF
) ();
  localparam int IW = $clog2(MASTER_NO);

  logic [MASTER_NO-1:0] bus_req;
  logic [MASTER_NO-1:0] bus_util;
  logic [SLAVE_NO-1:0]  slave_split;
  logic [SLAVE_NO-1:0]  slave_resume;
  logic [MASTER_NO-1:0] bus_grant;
  logic [MASTER_NO-1:0] split_en;
  logic [IW-1:0]        m_sel;
  logic                 bus_busy;

  modport master (
    input  bus_req, bus_util, slave_split, slave_resume,
    output bus_grant, split_en, m_sel, bus_busy
  );

  modport slave (
    output bus_req, bus_util, slave_split, slave_resume,
    input  bus_grant, split_en, m_sel, bus_busy
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester at or after ptr wins.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    idx = '0;
    any = 1'b0;
    // Walk offsets from farthest to nearest, so the nearest requester writes last and wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        any = 1'b1;
        idx = IW'((int'(ptr) + i) % N);
      end
    end
    gnt = '0;
    if (any) gnt[idx] = 1'b1;
  end
endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with an unused-grant timeout and split/resume tracking.
//   state | meaning
//   IDLE  | no grant
//   GRANT | granted, waiting for bus_util
//   BUSY  | transaction in progress
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int MASTER_NO     = MASTER_NO_DEF,
  parameter int SLAVE_NO      = SLAVE_NO_DEF,
  parameter int GRANT_TIMEOUT = 16
) (
  input logic             clk,
  input logic             rst_n,
  bus_arbiter_if.master   bus
);
  localparam int IW = $clog2(MASTER_NO);
  localparam int CW = $clog2(GRANT_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(GRANT_TIMEOUT);

  arb_state_t           state_q, state_d;
  logic [MASTER_NO-1:0] grant_q, grant_d;
  logic [IW-1:0]        m_sel_q, m_sel_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d, cnt_inc;
  logic [MASTER_NO-1:0] resumed_q, resumed_d;
  split_entry_t         tbl_q [MASTER_NO];
  split_entry_t         tbl_d [MASTER_NO];

  logic [MASTER_NO-1:0] pending, eligible, rr_gnt;
  logic [IW-1:0]        rr_idx, res_idx;
  logic                 rr_any, res_hit, split_hit;
  logic [SLAVE_IDX_W-1:0] split_idx;

  always_comb begin
    for (int m = 0; m < MASTER_NO; m++) pending[m] = tbl_q[m].valid;
  end

  assign eligible = (bus.bus_req & ~pending) | resumed_q;

  rr_arbiter #(.N(MASTER_NO)) u_rr (
    .req (eligible),
    .ptr (rr_ptr_q),
    .gnt (rr_gnt),
    .idx (rr_idx),
    .any (rr_any)
  );

  always_comb begin
    res_hit   = 1'b0;
    res_idx   = '0;
    split_hit = 1'b0;
    split_idx = '0;
    for (int m = MASTER_NO - 1; m >= 0; m--) begin
      if (resumed_q[m]) begin
        res_hit = 1'b1;
        res_idx = IW'(m);
      end
    end
    for (int s = SLAVE_NO - 1; s >= 0; s--) begin
      if (bus.slave_split[s]) begin
        split_hit = 1'b1;
        split_idx = SLAVE_IDX_W'(s);
      end
    end
  end

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    m_sel_d   = m_sel_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    resumed_d = resumed_q;
    tbl_d     = tbl_q;

    // Resumes are applied before splits, so a split in the same cycle can take a freed entry.
    for (int m = 0; m < MASTER_NO; m++) begin
      for (int s = 0; s < SLAVE_NO; s++) begin
        if (tbl_q[m].valid && bus.slave_resume[s] &&
            tbl_q[m].slave_idx == SLAVE_IDX_W'(s)) begin
          tbl_d[m]     = '0;
          resumed_d[m] = 1'b1;
        end
      end
    end

    unique case (state_q)
      IDLE: begin
        if (res_hit) begin
          state_d          = GRANT;
          grant_d          = '0;
          grant_d[res_idx] = 1'b1;
          m_sel_d          = res_idx;
          cnt_d            = '0;
          resumed_d[res_idx] = 1'b0;
        end else if (rr_any) begin
          state_d           = GRANT;
          grant_d           = rr_gnt;
          m_sel_d           = rr_idx;
          cnt_d             = '0;
          resumed_d[rr_idx] = 1'b0;
        end
      end
      GRANT: begin
        if (bus.bus_util[m_sel_q]) begin
          state_d = BUSY;
        end else if (!bus.bus_req[m_sel_q] || cnt_inc == CNT_MAX) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      BUSY: begin
        if (split_hit) begin
          tbl_d[m_sel_q] = '{valid: 1'b1, slave_idx: split_idx};
          state_d        = IDLE;
        end else if (!bus.bus_util[m_sel_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && state_d == IDLE) begin
      grant_d  = '0;
      rr_ptr_d = (m_sel_q == IW'(MASTER_NO - 1)) ? '0 : m_sel_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      m_sel_q   <= '0;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      resumed_q <= '0;
      for (int m = 0; m < MASTER_NO; m++) tbl_q[m] <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      m_sel_q   <= m_sel_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      resumed_q <= resumed_d;
      tbl_q     <= tbl_d;
    end
  end

  assign bus.bus_grant = grant_q;
  assign bus.m_sel     = m_sel_q;
  assign bus.bus_busy  = |grant_q;
  assign bus.split_en  = pending;
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

- Central arbiter for the serial system bus. It sits between the master ports and the slave-side split logic.
- Grants the shared bus to one master at a time using round-robin priority.
- Revokes grants that go unused and suspends a master when a slave splits its transaction.
- Gives the suspended master priority once the slave signals it can resume.

## Interface
- `MASTER_NO`, 2: number of master ports (≥2).
- `SLAVE_NO`, 3: number of slaves; width of split/resume vectors.
- `GRANT_TIMEOUT`, 16: max cycles a granted master may take to assert `bus_util` before the grant is revoked (≥1).
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `bus_req`  in  MASTER_NO  per-master request. A split master keeps it high until resumed.
- `bus_util`  in  MASTER_NO  per-master "transaction in progress". Only the granted master's bit is observed.
- `slave_split`  in  SLAVE_NO  1-cycle pulse: the slave splits the current transaction.
- `slave_resume`  in  SLAVE_NO  1-cycle pulse: the split slave is ready to complete.
- `bus_grant`  out  MASTER_NO  one-hot or zero grant.
- `split_en`  out  MASTER_NO  per-master "suspended by split" flag.
- `m_sel`  out  $clog2(MASTER_NO)  index of the granted master, for the bus mux. Holds its last value when there is no grant.
- `bus_busy`  out  1  high whenever `bus_grant` ≠ 0.

## Operation
- States:
  - **IDLE**: no grant.
  - **GRANT**: granted, waiting for `bus_util`.
  - **BUSY**: transaction in progress.
- **IDLE**
  - Eligible set = `bus_req & ~split_pending`, plus any resumed master.
  - A resumed master is chosen first; the lowest index wins if several are resumed.
  - Otherwise round-robin search starting at `rr_ptr`.
  - On a winner: go to GRANT, drive `bus_grant`/`m_sel`, clear the timeout counter.
- **GRANT**
  - `bus_util[m_sel]`=1 → BUSY.
  - `bus_req[m_sel]`=0 → IDLE.
  - Counter reaches `GRANT_TIMEOUT` → IDLE (revoke).
- **BUSY**
  - Any `slave_split` bit → record `{valid, slave index}` in the table entry for `m_sel`, set `split_en[m_sel]`, go to IDLE.
    - If several bits are set, the lowest slave index is recorded.
  - Otherwise `bus_util[m_sel]`=0 → IDLE.
  - A split wins over a simultaneous `bus_util` fall.
- Every exit from GRANT or BUSY sets `rr_ptr` = (`m_sel`+1) mod `MASTER_NO`.
- **Split table**: one entry per master. A split master is excluded from normal arbitration.
- **Resume**: `slave_resume[s]` while an entry is valid with slave s →
  - clear the entry and `split_en`;
  - mark the master resumed. The mark clears when that master is next granted.
- `slave_resume` matching no valid entry is ignored.
- `slave_split` outside BUSY is ignored.
- Resume and split in the same cycle: resume is processed first, so a new split is recordable.
- **Reset** (any time, mid-transaction included): state IDLE, `bus_grant`=0, `split_en`=0, `m_sel`=0, `bus_busy`=0, table cleared, `rr_ptr`=0, counter 0.

## Timing
- All outputs are registered.
- Grant latency: request sampled in IDLE at edge N → `bus_grant` high after edge N.
- Release: `bus_util` low sampled at edge N → grant low after edge N.
  - A new grant comes no earlier than after edge N+1, giving a minimum 1 idle cycle between owners.
- Timeout: grant high for exactly `GRANT_TIMEOUT` cycles if `bus_util` never rises.
- Split: `slave_split` at edge N → `bus_grant` low and `split_en` high after edge N.
- Resume: `slave_resume` at edge N → `split_en` low after edge N. Re-grant at the next edge if the arbiter is in IDLE.
- Counter width: $clog2(`GRANT_TIMEOUT`+1). It saturates and never wraps.

## Structure
- Package `bus_pkg`: `arb_state_t` enum (IDLE, GRANT, BUSY), `split_entry_t` struct {valid, slave_idx}, default `MASTER_NO`/`SLAVE_NO` constants.
- Sub-module `rr_arbiter`: combinational round-robin picker (req vector, pointer → one-hot and index).

## Test plan
All scenarios use `MASTER_NO`=2, `SLAVE_NO`=3, `GRANT_TIMEOUT`=4.
1. **Simultaneous request**: reset, then `bus_req`=2'b11 at the same edge → `bus_grant`=01 after 1 cycle. M0 asserts then drops `bus_util` → grant 00 for 1 cycle, then 10.
2. **Timeout**: `bus_req`=01, `bus_util` never asserted → `bus_grant`=01 for exactly 4 cycles, then 00. `rr_ptr`=1, so with `bus_req`=11 the next grant is 10.
3. **Split**: M0 in BUSY, `slave_split`=3'b010 → grant 00 and `split_en`=01. M1 (requesting) is granted next cycle while M0 is excluded.
4. **Resume**:
   - `slave_resume`=3'b100 → no effect.
   - `slave_resume`=3'b010 while M1 is busy → `split_en`=00. When M1 releases, M0 is granted first even with `bus_req`=11 and `rr_ptr`=0.
5. **Split/release collision**: split and `bus_util` fall in the same cycle → split recorded, `split_en` set.
6. **Reset mid-operation**: `rst_n` low during BUSY with a split entry → all outputs 0 immediately, before any clock edge. After release, `bus_req`=10 → grant 10 after 1 cycle.
